siso_link_ctrl: RTL
===================

Name: siso_link_ctrl

Overview:
- Sequencer for the 4-stage serial-in/serial-out D flip-flop shift chain.
- Accepts parallel words over a valid/ready handshake and drives them bit-serially into the chain input (sr_d).
- Tracks every bit in flight with a tag pipeline that mirrors the chain depth.
- Reassembles the bits arriving at the chain output (sr_q) into a parallel word, flagged by a one-cycle out_valid pulse.

Parameters:
- WIDTH, 8, bits per word; legal values 2..32.
- DEPTH, 4, number of flip-flop stages in the external shift chain; legal values 1..16.
- CNT_W, $clog2(WIDTH), width of the bit counter (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock shared with the shift chain.
- reset_n  in  1  asynchronous, active-low reset; also drives the chain's reset_n.
- in_valid  in  1  upstream word valid.
- in_data  in  WIDTH  upstream word.
- in_msb_first  in  1  bit order for this word; sampled with in_data.
- in_ready  out  1  controller can accept a word this cycle.
- sr_d  out  1  serial bit into the chain D input; registered.
- sr_q  in  1  serial bit from the chain Q output.
- out_valid  out  1  one-cycle pulse; out_data holds a complete word.
- out_data  out  WIDTH  reassembled word; held until the next out_valid.
- busy  out  1  state is SHIFT, or any tag is in flight.

Behaviour:
- Reset (asynchronous assert, synchronous release): the following values apply.
  - state = IDLE; bit counter = 0; sr_d = 0; all tags = 0.
  - out_valid = 0; out_data = 0; in_ready = 1 once reset_n is high; busy = 0.
- Handshake: a word is accepted at a rising edge where in_valid && in_ready.
  - in_data and in_msb_first are captured into a shift holding register at that edge.
  - in_data may change freely after acceptance.
- TX FSM has two states, IDLE and SHIFT.
  - IDLE: in_ready = 1. On accept, go to SHIFT with counter = 0.
  - SHIFT: drive one bit per cycle and increment the counter.
    - in_ready = 1 only in the cycle the counter equals WIDTH-1 (last bit).
    - Accept in that cycle: stay in SHIFT, counter = 0, no idle gap.
    - No accept in that cycle: return to IDLE.
- sr_d timing: cycle 0 is the first cycle after the accept edge. Bit k is on sr_d during cycle k, for k = 0..WIDTH-1.
  - Bit order: LSB first when in_msb_first = 0; MSB first when in_msb_first = 1.
  - In IDLE, sr_d = 0 (filler; never tagged valid).
- Tag pipeline: DEPTH stages {valid, last, msb_first}, shifted every clock in lockstep with the chain.
  - Stage 0 is loaded with the tag of the bit driven on sr_d.
  - Bit k therefore appears on sr_q in cycle k+DEPTH, when the stage DEPTH-1 tag is valid.
- RX collector: in each cycle where the output tag is valid, sr_q is shifted into the collect register using the tag's msb_first.
  - MSB-first words shift left; LSB-first words shift right, filling from bit WIDTH-1 down.
  - When the tag's last = 1, the completed word is loaded into out_data and out_valid = 1 in the next cycle (cycle WIDTH+DEPTH after accept).
  - End-to-end latency from the accept edge to out_valid high is WIDTH+DEPTH cycles (12 at the defaults).
- Back-to-back words: out_valid pulses every WIDTH cycles.
  - The collector restarts on the cycle after a last bit, with no loss and no overlap.
- There is no downstream backpressure. A consumer must take out_data on the out_valid pulse, or before the next pulse.
- busy falls in the cycle after the last tag leaves stage DEPTH-1.
- in_valid held high while in_ready = 0: no effect; the word is taken at the next in_ready cycle.
- Reset mid-word: every in-flight bit is discarded, no out_valid is produced, and in_ready = 1 again after release.
- DEPTH = 1 and WIDTH = 2 are the boundary configurations; both must meet the same latency rules.

Decomposition:
- Package siso_link_pkg:
  - typedef enum {IDLE, SHIFT} tx_state_t.
  - typedef struct {valid, last, msb_first} bit_tag_t.
  - Default constants WIDTH_DEF = 8 and DEPTH_DEF = 4.
- One sub-module, siso_tag_pipe: a DEPTH-stage bit_tag_t delay line with asynchronous active-low reset, mirroring the external chain.
- FSM, counter and collector stay in siso_link_ctrl.

Test Plan:
- Reset, then accept 0xA5 LSB-first -> sr_d = 1,0,1,0,0,1,0,1 in cycles 0..7; out_valid pulse in cycle 12; out_data = 0xA5.
- Accept 0x3C MSB-first -> sr_d = 0,0,1,1,1,1,0,0; out_data = 0x3C; out_valid in cycle 12.
- in_valid held high with words 0x01, 0x80, 0xFF, mixed bit order -> no sr_d gaps; out_valid in cycles 12, 20, 28 with the matching words; in_ready high only on last-bit cycles.
- in_valid pulsed while in SHIFT at counter 3 -> not accepted; in_ready = 0; word taken only if still valid at counter 7.
- reset_n low in cycle 5 of 0x5A -> out_valid never pulses for 0x5A; after release, 0x0F delivered with a clean 12-cycle latency.
- Parameter sweeps WIDTH = 2, DEPTH = 1 and WIDTH = 32, DEPTH = 16 -> out_valid exactly WIDTH+DEPTH cycles after accept; busy low after drain.

Source files
------------

// File: rtl/siso_link_pkg.sv
// rtl/siso_link_pkg.sv - shared types and defaults for the serial shift-chain link controller
package siso_link_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int DEPTH_DEF = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } tx_state_t;

   typedef struct packed {
      logic valid;
      logic last;
      logic msb_first;
   } bit_tag_t;

   localparam bit_tag_t TAG_NONE = '{valid: 1'b0, last: 1'b0, msb_first: 1'b0};

endpackage

// File: rtl/siso_tag_pipe.sv
// rtl/siso_tag_pipe.sv - DEPTH-stage tag delay line shadowing the external shift chain
module siso_tag_pipe
   import siso_link_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic     clk,
   input  logic     reset_n,
   input  bit_tag_t tag_in,
   output bit_tag_t tag_out,
   output logic     any_valid
);

   bit_tag_t stage [DEPTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= TAG_NONE;
         end
      end else begin
         stage[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign tag_out = stage[DEPTH-1];

   always_comb begin
      any_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         any_valid = any_valid | stage[i].valid;
      end
   end

endmodule

// File: rtl/siso_link_ctrl.sv
// rtl/siso_link_ctrl.sv - word-to-serial sequencer and collector around an external DFF shift chain
module siso_link_ctrl
   import siso_link_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_msb_first,
   output logic             in_ready,
   output logic             sr_d,
   input  logic             sr_q,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] PREV_CNT = CNT_W'(WIDTH - 2);

   tx_state_t        state;
   logic [CNT_W-1:0] bit_cnt;
   logic [WIDTH-1:0] hold;
   logic             hold_msb;
   bit_tag_t         sr_tag;
   bit_tag_t         tag_out;
   logic             tags_busy;
   logic [WIDTH-1:0] collect;
   logic [WIDTH-1:0] next_word;
   logic             last_bit;
   logic             accept;

   assign last_bit = (state == SHIFT) && (bit_cnt == LAST_CNT);
   assign in_ready = (state == IDLE) || last_bit;
   assign accept   = in_valid && in_ready;

   // sr_tag travels with sr_d so the tag pipe stays aligned with the chain's first flop
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         hold     <= '0;
         hold_msb <= 1'b0;
         sr_d     <= 1'b0;
         sr_tag   <= TAG_NONE;
      end else if (accept) begin
         state    <= SHIFT;
         bit_cnt  <= '0;
         hold_msb <= in_msb_first;
         sr_d     <= in_msb_first ? in_data[WIDTH-1] : in_data[0];
         hold     <= in_msb_first ? (in_data << 1) : (in_data >> 1);
         sr_tag   <= '{valid: 1'b1, last: 1'b0, msb_first: in_msb_first};
      end else if ((state == SHIFT) && !last_bit) begin
         bit_cnt <= bit_cnt + CNT_W'(1);
         sr_d    <= hold_msb ? hold[WIDTH-1] : hold[0];
         hold    <= hold_msb ? (hold << 1) : (hold >> 1);
         sr_tag  <= '{valid: 1'b1, last: (bit_cnt == PREV_CNT), msb_first: hold_msb};
      end else begin
         state   <= IDLE;
         bit_cnt <= '0;
         sr_d    <= 1'b0;
         sr_tag  <= TAG_NONE;
      end
   end

   siso_tag_pipe #(
      .DEPTH (DEPTH)
   ) u_tag_pipe (
      .clk       (clk),
      .reset_n   (reset_n),
      .tag_in    (sr_tag),
      .tag_out   (tag_out),
      .any_valid (tags_busy)
   );

   assign next_word = tag_out.msb_first ? {collect[WIDTH-2:0], sr_q}
                                        : {sr_q, collect[WIDTH-1:1]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         collect   <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (tag_out.valid) begin
            if (tag_out.last) begin
               collect   <= '0;
               out_data  <= next_word;
               out_valid <= 1'b1;
            end else begin
               collect <= next_word;
            end
         end
      end
   end

   assign busy = (state == SHIFT) || sr_tag.valid || tags_busy;

endmodule
